// File: rtl/mem_stage_dmem.sv
// mem_stage_dmem: data-memory responder for the MEM stage of the
// five-stage MIPS pipeline. Accepts one word load or store from the
// EX/MEM register, runs it against an internal synchronous RAM with a
// fixed access latency, and holds the front of the pipeline with
// `stall` until the single-cycle response is presented to MEM/WB.
//
// Parameters
//   DEPTH_WORDS : RAM depth in 32-bit words (power of two, >= 16)
//   LATENCY     : access cycles after acceptance (1..15)
//
// Ports
//   clock         in   rising-edge clock
//   reset_n       in   asynchronous active-low reset
//   MEM_MEM_REN   in   load request
//   MEM_MEM_WEN   in   store request
//   MEM_ALUResult in   byte address (wraps modulo 4*DEPTH_WORDS)
//   MEM_D2        in   store data
//   stall         out  freeze PC, IF/ID, ID/EX, EX/MEM while high
//   WB_ReadData   out  load result, valid with rdata_valid
//   rdata_valid   out  one-cycle pulse on good load completion
//   mem_err       out  one-cycle pulse on a rejected request
//
// Build option
//   DMEM_ALIGN_CHECK_EN : when defined, addresses with bits [1:0] != 0
//                         are treated as illegal requests.

module mem_stage_dmem #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        MEM_MEM_REN,
  input  logic        MEM_MEM_WEN,
  input  logic [31:0] MEM_ALUResult,
  input  logic [31:0] MEM_D2,
  output logic        stall,
  output logic [31:0] WB_ReadData,
  output logic        rdata_valid,
  output logic        mem_err
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q;
  logic [IDX_W-1:0]   idx_p0;
  logic [31:0]        wdata_p0;
  logic               is_rd_p0;
  logic               err_p0;
  logic               req;
  logic               misalign;
  logic               illegal;
  logic               accept;
  logic               commit;
  logic [31:0]        ram [DEPTH_WORDS];

  // Upper address bits fall outside the word index and are ignored;
  // the byte-offset bits only matter when alignment checking is built in.
  logic               unused_addr_bits;
  assign unused_addr_bits = ^{MEM_ALUResult[31:IDX_W+2], MEM_ALUResult[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = |MEM_ALUResult[1:0];
`else
  assign misalign = 1'b0;
`endif

  assign req     = MEM_MEM_REN | MEM_MEM_WEN;
  assign illegal = (MEM_MEM_REN & MEM_MEM_WEN) | misalign;
  assign accept  = (state_q == IDLE) && req;
  assign commit  = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign stall   = accept || (state_q == ACCESS);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = ACCESS;
      ACCESS:  if (cnt_q == 4'd0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 4'd0;
    end else if (accept) begin
      cnt_q <= CNT_INIT;
    end else if ((state_q == ACCESS) && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Stage p0: request captured at acceptance, held through ACCESS
  always_ff @(posedge clock) begin
    if (accept) begin
      idx_p0   <= MEM_ALUResult[IDX_W+1:2];
      wdata_p0 <= MEM_D2;
      is_rd_p0 <= MEM_MEM_REN;
      err_p0   <= illegal;
    end
  end

  // RAM is never reset; a reset before the commit edge returns the FSM
  // to IDLE, which removes the write enable.
  always_ff @(posedge clock) begin
    if (commit && !err_p0 && !is_rd_p0) begin
      ram[idx_p0] <= wdata_p0;
    end
  end

  // Response registers: pulses last only the RESP cycle, read data holds
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      WB_ReadData <= 32'd0;
      rdata_valid <= 1'b0;
      mem_err     <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      mem_err     <= 1'b0;
      if (commit) begin
        if (err_p0) begin
          mem_err     <= 1'b1;
          WB_ReadData <= 32'd0;
        end else if (is_rd_p0) begin
          rdata_valid <= 1'b1;
          WB_ReadData <= ram[idx_p0];
        end
      end
    end
  end

endmodule
